qed_consistency_checker: RTL and testbench

Retirement-side counterpart of the QED instruction duplicator. The duplicator remaps original instructions (x1–x15) onto a shadow register file (x16–x31) and replays them. This block watches register writebacks at the end of the pipeline. It queues each original-phase result and compares it against the matching duplicate-phase result, raising a sticky QED error on any inconsistency.

---
 rtl/qed_consistency_checker.sv | 182 ++++++++++++++++++
 tb/tb_qed_consistency_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qed_consistency_checker.sv
// Retirement-side QED checker: queues original-phase writebacks and compares them with duplicate-phase writebacks.
// Optional build macro QED_ERR_CAPTURE_EN adds err_rd/err_exp/err_got capture outputs.
module qed_consistency_checker #(
    parameter int DEPTH      = 16,
    parameter int REG_OFFSET = 16,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     wb_vld,
    input  logic                     wb_dup,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     phase_end,
    output logic                     stall_orig,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     qed_err,
    output logic [2:0]               err_type,
    output logic [CNT_W-1:0]         match_cnt
`ifdef QED_ERR_CAPTURE_EN
    ,
    output logic [4:0]               err_rd,
    output logic [31:0]              err_exp,
    output logic [31:0]              err_got
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0]       OFF      = 5'(REG_OFFSET);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      PTR_ZERO = (AW+1)'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] E_NONE = 3'd0;
    localparam logic [2:0] E_DATA = 3'd1;
    localparam logic [2:0] E_RD   = 3'd2;
    localparam logic [2:0] E_UNF  = 3'd3;
    localparam logic [2:0] E_OVF  = 3'd4;
    localparam logic [2:0] E_ILL  = 3'd5;
    localparam logic [2:0] E_INC  = 3'd6;

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [AW:0]      wr_ptr_r, rd_ptr_r, pending_r;
    logic             qed_err_r;
    logic [2:0]       err_type_r;
    logic [CNT_W-1:0] match_cnt_r;

    logic             acc_s, push_s, pop_s, match_s, flush_s, full_s, empty_s;
    logic [2:0]       err_code_s;
    logic [AW:0]      pend_next_s, wr_ptr_next_s, rd_ptr_next_s;
    logic [4:0]       head_rd_s;
    logic [31:0]      head_data_s;

    assign full_s      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign head_rd_s   = rd_mem[rd_ptr_r[AW-1:0]];
    assign head_data_s = data_mem[rd_ptr_r[AW-1:0]];
    assign acc_s       = ena && wb_vld && (wb_rd != 5'd0);

    // Classify the retiring writeback; priority falls out of the if-ordering.
    always_comb begin
        push_s     = 1'b0;
        pop_s      = 1'b0;
        match_s    = 1'b0;
        flush_s    = 1'b0;
        err_code_s = E_NONE;
        if (acc_s) begin
            if (!wb_dup) begin
                if (wb_rd >= OFF) begin
                    err_code_s = E_ILL;
                end else if (full_s) begin
                    err_code_s = E_OVF;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                if (wb_rd < OFF) begin
                    err_code_s = E_ILL;
                end else if (empty_s) begin
                    err_code_s = E_UNF;
                end else begin
                    pop_s = 1'b1;
                    if ((wb_rd - OFF) != head_rd_s) begin
                        err_code_s = E_RD;
                    end else if (wb_data != head_data_s) begin
                        err_code_s = E_DATA;
                    end else begin
                        match_s = 1'b1;
                    end
                end
            end
        end else begin
            push_s = 1'b0;
        end

        wr_ptr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_next_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        pend_next_s   = pending_r + (push_s ? PTR_ONE : PTR_ZERO) - (pop_s ? PTR_ONE : PTR_ZERO);

        // Segment end is judged on occupancy after this cycle's push/pop.
        if (ena && phase_end && (pend_next_s != PTR_ZERO)) begin
            flush_s       = 1'b1;
            rd_ptr_next_s = wr_ptr_next_s;
            pend_next_s   = PTR_ZERO;
            if (err_code_s == E_NONE) begin
                err_code_s = E_INC;
            end else begin
                err_code_s = err_code_s;
            end
        end else begin
            flush_s = 1'b0;
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem[wr_ptr_r[AW-1:0]]   <= wb_rd;
            data_mem[wr_ptr_r[AW-1:0]] <= wb_data;
        end
    end

    // Pointers, occupancy, match counter and sticky first-error record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            pending_r   <= PTR_ZERO;
            qed_err_r   <= 1'b0;
            err_type_r  <= E_NONE;
            match_cnt_r <= '0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            pending_r <= pend_next_s;
            if (match_s && (match_cnt_r != {CNT_W{1'b1}})) begin
                match_cnt_r <= match_cnt_r + CNT_ONE;
            end
            if ((err_code_s != E_NONE) && !qed_err_r) begin
                qed_err_r  <= 1'b1;
                err_type_r <= err_code_s;
            end
        end
    end

`ifdef QED_ERR_CAPTURE_EN
    logic [4:0]  err_rd_r;
    logic [31:0] err_exp_r, err_got_r;

    // Snapshot of the offending operands, taken only with the first error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_rd_r  <= 5'd0;
            err_exp_r <= 32'd0;
            err_got_r <= 32'd0;
        end else if ((err_code_s != E_NONE) && !qed_err_r) begin
            if ((err_code_s == E_RD) || (err_code_s == E_DATA)) begin
                err_rd_r  <= head_rd_s;
                err_exp_r <= head_data_s;
            end else begin
                err_rd_r  <= wb_rd;
                err_exp_r <= 32'd0;
            end
            err_got_r <= wb_data;
        end
    end

    assign err_rd  = err_rd_r;
    assign err_exp = err_exp_r;
    assign err_got = err_got_r;
`endif

    assign stall_orig = (pending_r == FULL_CNT);
    assign pending    = pending_r;
    assign qed_err    = qed_err_r;
    assign err_type   = err_type_r;
    assign match_cnt  = match_cnt_r;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed scoreboard bench for qed_consistency_checker (default parameters).
module tb_qed_consistency_checker;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, ena, wb_vld, wb_dup, phase_end;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_orig, qed_err;
    logic [4:0]  pending;
    logic [2:0]  err_type;
    logic [15:0] match_cnt;
`ifdef QED_ERR_CAPTURE_EN
    logic [4:0]  err_rd;
    logic [31:0] err_exp, err_got;
`endif

    qed_consistency_checker #(.DEPTH(DEPTH), .REG_OFFSET(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wb_vld(wb_vld), .wb_dup(wb_dup),
        .wb_rd(wb_rd), .wb_data(wb_data), .phase_end(phase_end),
        .stall_orig(stall_orig), .pending(pending), .qed_err(qed_err),
        .err_type(err_type), .match_cnt(match_cnt)
`ifdef QED_ERR_CAPTURE_EN
        , .err_rd(err_rd), .err_exp(err_exp), .err_got(err_got)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    typedef struct {
        logic [4:0] pend; logic stall; logic err; logic [2:0] et; logic [15:0] mc;
        logic [4:0] crd; logic [31:0] cexp; logic [31:0] cgot;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    logic        m_err;
    logic [2:0]  m_et;
    logic [15:0] m_mc;
    logic [4:0]  m_crd;
    logic [31:0] m_cexp, m_cgot;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_err = 1'b0; m_et = 3'd0; m_mc = 16'd0;
        m_crd = 5'd0; m_cexp = 32'd0; m_cgot = 32'd0;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".pending"},   64'(pending),    64'(e.pend));
        check({tag, ".stall"},     64'(stall_orig), 64'(e.stall));
        check({tag, ".qed_err"},   64'(qed_err),    64'(e.err));
        check({tag, ".err_type"},  64'(err_type),   64'(e.et));
        check({tag, ".match_cnt"}, 64'(match_cnt),  64'(e.mc));
`ifdef QED_ERR_CAPTURE_EN
        check({tag, ".err_rd"},  64'(err_rd),  64'(e.crd));
        check({tag, ".err_exp"}, 64'(err_exp), 64'(e.cexp));
        check({tag, ".err_got"}, 64'(err_got), 64'(e.cgot));
`endif
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.pend = 5'(mq.size()); e.stall = (mq.size() == DEPTH);
        e.err = m_err; e.et = m_et; e.mc = m_mc;
        e.crd = m_crd; e.cexp = m_cexp; e.cgot = m_cgot;
        return e;
    endfunction

    // One clock of stimulus: drive, predict, then compare just after the edge.
    task automatic step(input string tag, input logic v, input logic d, input logic [4:0] rd,
                        input logic [31:0] data, input logic pe);
        logic [2:0] ec;
        ent_t h;
        exp_t e;
        @(negedge clk);
        wb_vld = v; wb_dup = d; wb_rd = rd; wb_data = data; phase_end = pe;
        ec = 3'd0;
        h.rd = 5'd0; h.data = 32'd0;
        if (ena && v && rd != 5'd0) begin
            if (!d) begin
                if (rd >= 5'd16) ec = 3'd5;
                else if (mq.size() == DEPTH) ec = 3'd4;
                else mq.push_back('{rd, data});
            end else begin
                if (rd < 5'd16) ec = 3'd5;
                else if (mq.size() == 0) ec = 3'd3;
                else begin
                    h = mq.pop_front();
                    if (5'(rd - 5'd16) != h.rd) ec = 3'd2;
                    else if (data != h.data) ec = 3'd1;
                    else if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                end
            end
        end
        if (ena && pe && mq.size() != 0) begin
            if (ec == 3'd0) ec = 3'd6;
            mq.delete();
        end
        if (ec != 3'd0 && !m_err) begin
            m_err = 1'b1; m_et = ec; m_cgot = data;
            if (ec == 3'd1 || ec == 3'd2) begin m_crd = h.rd; m_cexp = h.data; end
            else begin m_crd = rd; m_cexp = 32'd0; end
        end
        sb.push_back(snapshot());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(tag, e);
        wb_vld = 1'b0; phase_end = 1'b0;
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_clear();
        compare("reset", snapshot());
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic dup_head(input string tag);
        ent_t h;
        h = mq[0];
        step(tag, 1'b1, 1'b1, 5'(h.rd + 5'd16), h.data, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; wb_vld = 1'b0; wb_dup = 1'b0;
        wb_rd = 5'd0; wb_data = 32'd0; phase_end = 1'b0;
        model_clear();
        do_reset();

        // Matched pair and x0 writes
        step("orig_x5", 1'b1, 1'b0, 5'd5,  32'h1234_5678, 1'b0);
        step("dup_x21", 1'b1, 1'b1, 5'd21, 32'h1234_5678, 1'b0);
        step("x0_orig", 1'b1, 1'b0, 5'd0,  32'hDEAD_BEEF, 1'b0);
        step("x0_dup",  1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0);

        // Full rounds across pointer wrap, then overflow
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++)
                step("fill", 1'b1, 1'b0, 5'(i % 15 + 1), $urandom, 1'b0);
            for (int i = 0; i < DEPTH; i++)
                dup_head("drain");
        end
        for (int i = 0; i < DEPTH; i++)
            step("fill_ovf", 1'b1, 1'b0, 5'(i % 15 + 1), $urandom, 1'b0);
        step("overflow", 1'b1, 1'b0, 5'd7, 32'h0000_0077, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            dup_head("drain_ovf");

        // Data and rd mismatches
        do_reset();
        step("orig_x3", 1'b1, 1'b0, 5'd3,  32'h0000_000A, 1'b0);
        step("dmis",    1'b1, 1'b1, 5'd19, 32'h0000_000B, 1'b0);
        do_reset();
        step("orig_x4", 1'b1, 1'b0, 5'd4,  32'h0000_0044, 1'b0);
        step("rdmis",   1'b1, 1'b1, 5'd25, 32'h0000_0044, 1'b0);

        // Underflow, illegal rd, and illegal-over-underflow priority
        do_reset();
        step("underflow", 1'b1, 1'b1, 5'd17, 32'h0000_0011, 1'b0);
        do_reset();
        step("ill_orig",  1'b1, 1'b0, 5'd20, 32'h0000_0020, 1'b0);
        do_reset();
        step("ill_dup",   1'b1, 1'b1, 5'd5,  32'h0000_0005, 1'b0);

        // Incomplete segment, then first-error hold
        do_reset();
        step("seg_o1", 1'b1, 1'b0, 5'd1, 32'h0000_0101, 1'b0);
        step("seg_o2", 1'b1, 1'b0, 5'd2, 32'h0000_0202, 1'b0);
        step("seg_o3", 1'b1, 1'b0, 5'd3, 32'h0000_0303, 1'b0);
        dup_head("seg_d1");
        step("phase_end", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step("pe_idle",   1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step("hold_o",    1'b1, 1'b0, 5'd3,  32'h0000_000A, 1'b0);
        step("hold_d",    1'b1, 1'b1, 5'd19, 32'h0000_000B, 1'b0);

        // ena=0 freezes state; reset mid-segment clears everything
        do_reset();
        step("en_o", 1'b1, 1'b0, 5'd4, 32'h0000_0004, 1'b0);
        ena = 1'b0;
        step("ena_off", 1'b1, 1'b1, 5'd20, 32'hFFFF_FFFF, 1'b1);
        ena = 1'b1;
        for (int i = 0; i < 4; i++)
            step("pend5", 1'b1, 1'b0, 5'(i + 6), $urandom, 1'b0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
